spi_command_slave: RTL and testbench

SPI mode-0 slave that feeds the DSP engine's command path. It deserialises MOSI bytes into single-cycle `command_out`/`command_out_ready` strobes, which connect to the engine's `command_in`/`command_in_ready`. It serialises the engine's controller output byte onto MISO in the same frame. All SPI pins are asynchronous to `clk` and are synchronised inside the block.

---
 rtl/spi_command_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_command_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_slave.sv
// SPI mode-0 slave: MOSI bytes become single-cycle command strobes, reply byte shifts out on MISO.
// Latency: pin edge acted on sync_stages+1 clk cycles later; command/overrun/abort strobes registered one cycle on.
// Backpressure: none towards the master; a byte completing while fifo_full is high is dropped and flagged by overrun.
module spi_command_slave #(
    parameter int sync_stages = 2,
    parameter int byte_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [byte_width-1:0] tx_byte,
    input  logic                  fifo_full,
    output logic [byte_width-1:0] command_out,
    output logic                  command_out_ready,
    output logic                  overrun,
    output logic                  frame_aborted,
    output logic [7:0]            frame_bytes
);

    localparam int               cnt_w    = $clog2(byte_width);
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(byte_width - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_nxt;
    logic [sync_stages-1:0]  sck_sync, cs_sync, mosi_sync;
    logic                    sck_d, cs_d;
    logic [sync_stages:0]    warm;
    logic                    armed;
    logic [cnt_w-1:0]        bit_cnt;
    logic [byte_width-1:0]   rx_shift, tx_shift;
    logic                    byte_seen;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic frame_start, frame_end, shift_in, shift_out, byte_done, abort;

    assign sck_s    = sck_sync[sync_stages-1];
    assign cs_s     = cs_sync[sync_stages-1];
    assign mosi_s   = mosi_sync[sync_stages-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    // Pin synchronisers plus one delayed copy for edge detection; warm tracks when the chain holds real pin values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            warm      <= '0;
        end else begin
            sck_sync  <= {sck_sync[sync_stages-2:0], sck};
            cs_sync   <= {cs_sync[sync_stages-2:0], cs_n};
            mosi_sync <= {mosi_sync[sync_stages-2:0], mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            warm      <= {warm[sync_stages-1:0], 1'b1};
        end
    end

    // Only accept a frame once cs_n has genuinely been seen high, so a frame in flight at reset release is skipped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else if (warm[sync_stages] && cs_s) begin
            armed <= 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle frame events; sck edges only count while ACTIVE
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                shift_in  = sck_rise;
                shift_out = sck_fall;
                if (cs_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A final bit landing with the cs_n rise still completes the byte rather than aborting it
        byte_done = shift_in && (bit_cnt == last_bit);
        abort     = frame_end && (bit_cnt != '0) && !byte_done;
    end

    // Shift registers, bit/byte counters and reply reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            frame_bytes <= 8'd0;
            byte_seen   <= 1'b0;
        end else if (frame_start) begin
            bit_cnt     <= '0;
            frame_bytes <= 8'd0;
            tx_shift    <= tx_byte;
            byte_seen   <= 1'b0;
        end else begin
            if (shift_in) begin
                rx_shift <= {rx_shift[byte_width-2:0], mosi_s};
                bit_cnt  <= byte_done ? '0 : bit_cnt + cnt_w'(1);
            end
            if (byte_done) begin
                frame_bytes <= frame_bytes + 8'd1;
                byte_seen   <= 1'b1;
            end
            if (abort) begin
                bit_cnt <= '0;
            end
            if (shift_out) begin
                if (bit_cnt == '0 && byte_seen) begin
                    tx_shift <= tx_byte;
                end else begin
                    tx_shift <= {tx_shift[byte_width-2:0], 1'b0};
                end
            end
        end
    end

    // Registered strobes; command_out only moves when the engine can take the byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            command_out       <= '0;
            command_out_ready <= 1'b0;
            overrun           <= 1'b0;
            frame_aborted     <= 1'b0;
        end else begin
            command_out_ready <= byte_done && !fifo_full;
            overrun           <= byte_done && fifo_full;
            frame_aborted     <= abort;
            if (byte_done && !fifo_full) begin
                command_out <= {rx_shift[byte_width-2:0], mosi_s};
            end
        end
    end

    assign miso = (state == ACTIVE) ? tx_shift[byte_width-1] : 1'b0;

endmodule

// File: tb/tb_spi_command_slave.sv
module tb_spi_command_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_byte;
    logic       fifo_full;
    logic [7:0] command_out;
    logic       command_out_ready;
    logic       overrun;
    logic       frame_aborted;
    logic [7:0] frame_bytes;

    int checks = 0;
    int errors = 0;

    int         rdy_cnt, ovr_cnt, abt_cnt;
    logic [7:0] rx_q[$];

    spi_command_slave #(.sync_stages(2), .byte_width(8)) dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .tx_byte(tx_byte),
        .fifo_full(fifo_full),
        .command_out(command_out),
        .command_out_ready(command_out_ready),
        .overrun(overrun),
        .frame_aborted(frame_aborted),
        .frame_bytes(frame_bytes)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (command_out_ready) begin
            rdy_cnt++;
            rx_q.push_back(command_out);
        end
        if (overrun)       ovr_cnt++;
        if (frame_aborted) abt_cnt++;
    end

    task automatic clear_mon;
        rdy_cnt = 0;
        ovr_cnt = 0;
        abt_cnt = 0;
        rx_q.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] first_tx);
        tx_byte = first_tx;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(10);
    endtask

    task automatic end_frame;
        wait_clk(8);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    // Shift bits hi..lo of mo; MISO is captured at each sck rise; next_tx is presented after the last rise
    task automatic send_bits(input logic [7:0] mo, input int hi, input int lo,
                             input logic [7:0] next_tx, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = hi; i >= lo; i--) begin
            mosi = mo[i];
            wait_clk(8);
            sck = 1'b1;
            mi[i] = miso;
            if (i == lo) tx_byte = next_tx;
            wait_clk(8);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_byte = 8'h00; fifo_full = 1'b0;
        clear_mon();
        wait_clk(3);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        checks++; if (command_out !== 8'h00) begin errors++; $display("FAIL reset_command_out got %h want 00", command_out); end
        checks++; if (command_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", command_out_ready); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (frame_aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", frame_aborted); end
        checks++; if (frame_bytes !== 8'h00) begin errors++; $display("FAIL reset_frame_bytes got %h want 00", frame_bytes); end
        reset = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_single_byte;
        logic [7:0] m;
        clear_mon();
        start_frame(8'h00);
        send_bits(8'hA5, 7, 0, 8'h00, m);
        end_frame();
        checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL single_ready_count got %0d want 1", rdy_cnt); end
        checks++; if (command_out !== 8'hA5) begin errors++; $display("FAIL single_command_out got %h want a5", command_out); end
        checks++; if (frame_bytes !== 8'd1) begin errors++; $display("FAIL single_frame_bytes got %0d want 1", frame_bytes); end
        checks++; if (ovr_cnt !== 0 || abt_cnt !== 0) begin errors++; $display("FAIL single_side_strobes got ovr %0d abt %0d want 0 0", ovr_cnt, abt_cnt); end
    endtask

    task automatic test_reply;
        logic [7:0] m;
        clear_mon();
        start_frame(8'h3C);
        send_bits(8'h00, 7, 0, 8'h00, m);
        end_frame();
        checks++; if (m !== 8'h3C) begin errors++; $display("FAIL reply_miso got %h want 3c", m); end
        checks++; if (rdy_cnt !== 1 || command_out !== 8'h00) begin errors++; $display("FAIL reply_rx got cnt %0d data %h want 1 00", rdy_cnt, command_out); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] m0, m1, m2;
        clear_mon();
        start_frame(8'hE1);
        send_bits(8'h12, 7, 0, 8'h77, m0);
        send_bits(8'h34, 7, 0, 8'h00, m1);
        send_bits(8'h56, 7, 0, 8'h00, m2);
        end_frame();
        checks++; if (rdy_cnt !== 3) begin errors++; $display("FAIL b2b_ready_count got %0d want 3", rdy_cnt); end
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34 || rx_q[2] !== 8'h56) begin
            errors++; $display("FAIL b2b_order got %p want 12 34 56", rx_q);
        end
        checks++; if (m0 !== 8'hE1) begin errors++; $display("FAIL b2b_miso0 got %h want e1", m0); end
        checks++; if (m1 !== 8'h77) begin errors++; $display("FAIL b2b_miso1 got %h want 77", m1); end
        checks++; if (frame_bytes !== 8'd3) begin errors++; $display("FAIL b2b_frame_bytes got %0d want 3", frame_bytes); end
    endtask

    task automatic test_abort;
        logic [7:0] m;
        clear_mon();
        start_frame(8'h00);
        send_bits(8'hFF, 7, 3, 8'h00, m);
        end_frame();
        checks++; if (abt_cnt !== 1) begin errors++; $display("FAIL abort_count got %0d want 1", abt_cnt); end
        checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL abort_ready got %0d want 0", rdy_cnt); end
        start_frame(8'h00);
        send_bits(8'hC3, 7, 0, 8'h00, m);
        end_frame();
        checks++; if (rdy_cnt !== 1 || command_out !== 8'hC3) begin errors++; $display("FAIL abort_next_frame got cnt %0d data %h want 1 c3", rdy_cnt, command_out); end
        checks++; if (abt_cnt !== 1) begin errors++; $display("FAIL abort_no_extra got %0d want 1", abt_cnt); end
    endtask

    task automatic test_overrun;
        logic [7:0] m;
        clear_mon();
        fifo_full = 1'b1;
        start_frame(8'h00);
        send_bits(8'h99, 7, 0, 8'h00, m);
        end_frame();
        fifo_full = 1'b0;
        checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL overrun_count got %0d want 1", ovr_cnt); end
        checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL overrun_ready got %0d want 0", rdy_cnt); end
        checks++; if (command_out !== 8'hC3) begin errors++; $display("FAIL overrun_hold got %h want c3", command_out); end
        checks++; if (frame_bytes !== 8'd1) begin errors++; $display("FAIL overrun_frame_bytes got %0d want 1", frame_bytes); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] m;
        clear_mon();
        start_frame(8'hFF);
        send_bits(8'hF0, 7, 5, 8'hFF, m);
        reset = 1'b0;
        #1;
        checks++; if (command_out !== 8'h00) begin errors++; $display("FAIL midreset_command_out got %h want 00", command_out); end
        checks++; if (frame_bytes !== 8'h00) begin errors++; $display("FAIL midreset_frame_bytes got %h want 00", frame_bytes); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midreset_miso got %b want 0", miso); end
        checks++;
        if (command_out_ready !== 1'b0 || overrun !== 1'b0 || frame_aborted !== 1'b0) begin
            errors++; $display("FAIL midreset_strobes got %b%b%b want 000", command_out_ready, overrun, frame_aborted);
        end
        wait_clk(3);
        reset = 1'b1;
        send_bits(8'hF0, 4, 0, 8'h00, m);
        end_frame();
        checks++; if (rdy_cnt !== 0 || abt_cnt !== 0 || ovr_cnt !== 0) begin errors++; $display("FAIL midreset_rejoin got rdy %0d abt %0d ovr %0d want 0 0 0", rdy_cnt, abt_cnt, ovr_cnt); end
        start_frame(8'h00);
        send_bits(8'h5A, 7, 0, 8'h00, m);
        end_frame();
        checks++; if (rdy_cnt !== 1 || command_out !== 8'h5A) begin errors++; $display("FAIL midreset_new_frame got cnt %0d data %h want 1 5a", rdy_cnt, command_out); end
    endtask

    // Random frames checked against a list-level model: accepted bytes in order, overruns counted, replies echoed
    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] exp_last;
        int         exp_ovr;
        logic [7:0] cur_tx, nxt_tx, mo, m;
        int         nb;
        clear_mon();
        exp_ovr  = 0;
        exp_last = command_out;
        for (int f = 0; f < 6; f++) begin
            nb     = $urandom_range(1, 4);
            cur_tx = 8'($urandom);
            start_frame(cur_tx);
            for (int b = 0; b < nb; b++) begin
                mo        = 8'($urandom);
                nxt_tx    = 8'($urandom);
                fifo_full = ($urandom_range(0, 3) == 0);
                if (fifo_full) exp_ovr++;
                else begin exp_q.push_back(mo); exp_last = mo; end
                send_bits(mo, 7, 0, nxt_tx, m);
                checks++; if (m !== cur_tx) begin errors++; $display("FAIL rand_miso f%0d b%0d got %h want %h", f, b, m, cur_tx); end
                cur_tx = nxt_tx;
            end
            end_frame();
            fifo_full = 1'b0;
            checks++; if (frame_bytes !== 8'(nb)) begin errors++; $display("FAIL rand_frame_bytes f%0d got %0d want %0d", f, frame_bytes, nb); end
        end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_ready_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_rx idx %0d got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL rand_overrun got %0d want %0d", ovr_cnt, exp_ovr); end
        checks++; if (command_out !== exp_last) begin errors++; $display("FAIL rand_command_out got %h want %h", command_out, exp_last); end
        checks++; if (abt_cnt !== 0) begin errors++; $display("FAIL rand_aborted got %0d want 0", abt_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_reply();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
